// File: rtl/wbi_stage_fifo.sv
// wbi_stage_fifo: two-channel staging buffer for the Wishbone daisy-chain
// valid/ready interconnect. The command channel carries previous -> next,
// the response channel next -> previous. Each channel is an independent
// circular FIFO with a registered input ready.
// Optional feature macro: WBI_STAGE_BYPASS_EN (0-cycle pass-through when empty).

module wbi_stage_chan #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     mclk,
  input  logic                     reset_n,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic [W-1:0]             in_pkt,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [W-1:0]             out_pkt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  // Storage is never reset; the output gating keeps stale entries invisible.
  logic [W-1:0]    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LW-1:0]   level_reg;
  logic [LW-1:0]   level_next;
  logic            in_rdy_reg;
  logic            empty;
  logic            push;
  logic            pop;
  logic            wr_en;
  logic            rd_en;

  assign empty = (level_reg == '0);
  assign push  = in_val && in_rdy_reg;
  assign pop   = out_val && out_rdy;

`ifdef WBI_STAGE_BYPASS_EN
  // A packet consumed straight through an empty FIFO is never written.
  assign wr_en = push && !(empty && out_rdy);
`else
  assign wr_en = push;
`endif
  assign rd_en = pop && !empty;

  // Output mux: FIFO head when occupied, bypassed input or zeros otherwise.
  always_comb begin
    out_val = 1'b0;
    out_pkt = '0;
    if (!empty) begin
      out_val = 1'b1;
      out_pkt = mem[rd_ptr];
    end
`ifdef WBI_STAGE_BYPASS_EN
    else if (in_val) begin
      out_val = 1'b1;
      out_pkt = in_pkt;
    end
`endif
  end

  // Occupancy after this cycle's write/read.
  always_comb begin
    level_next = level_reg;
    case ({wr_en, rd_en})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  // Pointer, level and registered-ready state; ready looks only at next level.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_reg  <= '0;
      in_rdy_reg <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      level_reg  <= level_next;
      in_rdy_reg <= (level_next != FULL);
    end
  end

  // Entry write port.
  always_ff @(posedge mclk) begin
    if (wr_en) mem[wr_ptr] <= in_pkt;
  end

  assign in_rdy = in_rdy_reg;
  assign level  = level_reg;

endmodule

module wbi_stage_fifo #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BW        = 4,
  parameter int BL        = 10,
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int CMD_W     = AW + 1 + DW + BW + 4 + BL,
  parameter int RES_W     = DW + 4 + 4
) (
  input  logic                         mclk,
  input  logic                         reset_n,
  input  logic                         wbp_cmd_wval_i,
  output logic                         wbp_cmd_wrdy_o,
  input  logic [CMD_W-1:0]             wbp_cmd_pkt_i,
  output logic                         wbd_cmd_wval_o,
  input  logic                         wbd_cmd_wrdy_i,
  output logic [CMD_W-1:0]             wbd_cmd_pkt_o,
  input  logic                         wbd_res_rval_i,
  output logic                         wbd_res_rrdy_o,
  input  logic [RES_W-1:0]             wbd_res_pkt_i,
  output logic                         wbp_res_rval_o,
  input  logic                         wbp_res_rrdy_i,
  output logic [RES_W-1:0]             wbp_res_pkt_o,
  output logic [$clog2(CMD_DEPTH):0]   cmd_level_o,
  output logic [$clog2(RES_DEPTH):0]   res_level_o
);

  wbi_stage_chan #(.W(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd (
    .mclk    (mclk),
    .reset_n (reset_n),
    .in_val  (wbp_cmd_wval_i),
    .in_rdy  (wbp_cmd_wrdy_o),
    .in_pkt  (wbp_cmd_pkt_i),
    .out_val (wbd_cmd_wval_o),
    .out_rdy (wbd_cmd_wrdy_i),
    .out_pkt (wbd_cmd_pkt_o),
    .level   (cmd_level_o)
  );

  wbi_stage_chan #(.W(RES_W), .DEPTH(RES_DEPTH)) u_res (
    .mclk    (mclk),
    .reset_n (reset_n),
    .in_val  (wbd_res_rval_i),
    .in_rdy  (wbd_res_rrdy_o),
    .in_pkt  (wbd_res_pkt_i),
    .out_val (wbp_res_rval_o),
    .out_rdy (wbp_res_rrdy_i),
    .out_pkt (wbp_res_pkt_o),
    .level   (res_level_o)
  );

endmodule

// File: tb/tb_wbi_stage_fifo.sv
// Directed self-checking bench for wbi_stage_fifo (default 4-entry FIFOs).
// Inputs change just after the falling edge; outputs are checked there too.

module tb_wbi_stage_fifo;

  localparam int CMD_W = 83;
  localparam int RES_W = 40;
`ifdef WBI_STAGE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             mclk = 1'b0;
  logic             reset_n = 1'b0;
  logic             wbp_cmd_wval_i = 1'b0;
  logic             wbp_cmd_wrdy_o;
  logic [CMD_W-1:0] wbp_cmd_pkt_i = '0;
  logic             wbd_cmd_wval_o;
  logic             wbd_cmd_wrdy_i = 1'b0;
  logic [CMD_W-1:0] wbd_cmd_pkt_o;
  logic             wbd_res_rval_i = 1'b0;
  logic             wbd_res_rrdy_o;
  logic [RES_W-1:0] wbd_res_pkt_i = '0;
  logic             wbp_res_rval_o;
  logic             wbp_res_rrdy_i = 1'b0;
  logic [RES_W-1:0] wbp_res_pkt_o;
  logic [2:0]       cmd_level_o;
  logic [2:0]       res_level_o;

  int tests = 0;
  int fails = 0;

  wbi_stage_fifo dut (
    .mclk           (mclk),
    .reset_n        (reset_n),
    .wbp_cmd_wval_i (wbp_cmd_wval_i),
    .wbp_cmd_wrdy_o (wbp_cmd_wrdy_o),
    .wbp_cmd_pkt_i  (wbp_cmd_pkt_i),
    .wbd_cmd_wval_o (wbd_cmd_wval_o),
    .wbd_cmd_wrdy_i (wbd_cmd_wrdy_i),
    .wbd_cmd_pkt_o  (wbd_cmd_pkt_o),
    .wbd_res_rval_i (wbd_res_rval_i),
    .wbd_res_rrdy_o (wbd_res_rrdy_o),
    .wbd_res_pkt_i  (wbd_res_pkt_i),
    .wbp_res_rval_o (wbp_res_rval_o),
    .wbp_res_rrdy_i (wbp_res_rrdy_i),
    .wbp_res_pkt_o  (wbp_res_pkt_o),
    .cmd_level_o    (cmd_level_o),
    .res_level_o    (res_level_o)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance to the next check point (just after the falling edge).
  task automatic tick();
    @(negedge mclk);
    #1;
  endtask

  function automatic logic [CMD_W-1:0] mk_cmd(input logic [31:0] adr, input logic we,
      input logic [31:0] dat, input logic [3:0] sel, input logic [3:0] tid, input logic [9:0] bl);
    return {adr, we, dat, sel, tid, bl};
  endfunction

  function automatic logic [RES_W-1:0] mk_res(input logic [31:0] dat, input logic [3:0] tid);
    return {dat, 1'b1, 1'b0, 1'b0, 1'b0, tid};
  endfunction

  logic [CMD_W-1:0] p1;
  logic [RES_W-1:0] r_head;
  logic [3:0]       tid_v;

  initial begin
    // ---------------- reset state ----------------
    tick();
    check("rst_cmd_level", cmd_level_o, 0);
    check("rst_res_level", res_level_o, 0);
    check("rst_cmd_wval", wbd_cmd_wval_o, 0);
    check("rst_res_rval", wbp_res_rval_o, 0);
    check("rst_cmd_pkt", wbd_cmd_pkt_o, 0);
    check("rst_res_pkt", wbp_res_pkt_o, 0);
    reset_n = 1'b1;
    tick();
    check("rst_cmd_wrdy", wbp_cmd_wrdy_o, 1);
    check("rst_res_rrdy", wbd_res_rrdy_o, 1);

    // ---------------- single write ----------------
    p1 = mk_cmd(32'h1000_0040, 1'b1, 32'hDEAD_BEEF, 4'hF, 4'd3, 10'd1);
    wbd_cmd_wrdy_i = 1'b1;
    wbp_cmd_wval_i = 1'b1;
    wbp_cmd_pkt_i  = p1;
    #1;
    check("single_same_cycle_wval", wbd_cmd_wval_o, BYP);
    tick();
    wbp_cmd_wval_i = 1'b0;
    wbp_cmd_pkt_i  = '0;
    #1;
    if (!BYP) begin
      check("single_wval_next", wbd_cmd_wval_o, 1);
      check("single_pkt", wbd_cmd_pkt_o, p1);
      check("single_level1", cmd_level_o, 1);
      tick();
    end
    check("single_level0", cmd_level_o, 0);
    check("single_wval_off", wbd_cmd_wval_o, 0);
    check("single_pkt_zero", wbd_cmd_pkt_o, 0);

    // ---------------- fill and stall ----------------
    wbd_cmd_wrdy_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("fill_wrdy_%0d", k), wbp_cmd_wrdy_o, (k < 4) ? 1 : 0);
      wbp_cmd_wval_i = 1'b1;
      wbp_cmd_pkt_i  = mk_cmd(32'h2000_0000 + k, 1'b0, 32'h0, 4'h0, 4'(k), 10'd0);
      tick();
    end
    wbp_cmd_wval_i = 1'b0;
    check("fill_level4", cmd_level_o, 4);
    check("fill_wrdy_low", wbp_cmd_wrdy_o, 0);
    check("fill_head_tid0", wbd_cmd_pkt_o[13:10], 0);
    wbd_cmd_wrdy_i = 1'b1;
    tick();
    check("drain_wrdy_rise", wbp_cmd_wrdy_o, 1);
    check("drain_level3", cmd_level_o, 3);
    for (int k = 1; k < 4; k++) begin
      tid_v = wbd_cmd_pkt_o[13:10];
      check($sformatf("drain_tid_%0d", k), tid_v, k);
      check($sformatf("drain_wval_%0d", k), wbd_cmd_wval_o, 1);
      tick();
    end
    check("drain_empty", cmd_level_o, 0);

    // ---------------- streaming throughput (response path) ----------------
    wbp_res_rrdy_i = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (!BYP) begin
        check($sformatf("stream_rval_%0d", k), wbp_res_rval_o, (k >= 1 && k <= 16) ? 1 : 0);
        if (k >= 1 && k <= 16)
          check($sformatf("stream_dat_%0d", k), wbp_res_pkt_o[39:8], k - 1);
      end
      check($sformatf("stream_level_le1_%0d", k), res_level_o <= 1, 1);
      if (k < 16) begin
        wbd_res_rval_i = 1'b1;
        wbd_res_pkt_i  = mk_res(32'(k), 4'(k));
      end else begin
        wbd_res_rval_i = 1'b0;
        wbd_res_pkt_i  = '0;
      end
      tick();
    end
    check("stream_res_empty", res_level_o, 0);

    // ---------------- channel independence ----------------
    wbp_res_rrdy_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wbd_res_rval_i = 1'b1;
      wbd_res_pkt_i  = mk_res(32'hA0 + k, 4'(8 + k));
      tick();
    end
    wbd_res_rval_i = 1'b0;
    wbd_res_pkt_i  = '0;
    r_head = mk_res(32'hA0, 4'd8);
    wbd_cmd_wrdy_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wbp_cmd_wval_i = 1'b1;
      wbp_cmd_pkt_i  = mk_cmd(32'h3000_0000 + k, 1'b1, 32'(k), 4'h3, 4'(k), 10'd2);
      tick();
      check($sformatf("indep_res_level_%0d", k), res_level_o, 2);
      check($sformatf("indep_rval_%0d", k), wbp_res_rval_o, 1);
      check($sformatf("indep_res_pkt_%0d", k), wbp_res_pkt_o, r_head);
    end
    wbp_cmd_wval_i = 1'b0;
    tick();
    tick();
    check("indep_cmd_drained", cmd_level_o, 0);

    // ---------------- reset mid-operation ----------------
    wbd_cmd_wrdy_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wbp_cmd_wval_i = 1'b1;
      wbp_cmd_pkt_i  = mk_cmd(32'h4000_0000 + k, 1'b0, 32'h55, 4'h1, 4'(k), 10'd0);
      tick();
    end
    wbp_cmd_wval_i = 1'b0;
    check("pre_rst_cmd_level", cmd_level_o, 3);
    check("pre_rst_res_level", res_level_o, 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_cmd_level", cmd_level_o, 0);
    check("arst_res_level", res_level_o, 0);
    check("arst_cmd_wval", wbd_cmd_wval_o, 0);
    check("arst_res_rval", wbp_res_rval_o, 0);
    check("arst_cmd_pkt", wbd_cmd_pkt_o, 0);
    check("arst_res_pkt", wbp_res_pkt_o, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_cmd_wrdy", wbp_cmd_wrdy_o, 1);
    check("post_rst_res_rrdy", wbd_res_rrdy_o, 1);
    check("post_rst_cmd_level", cmd_level_o, 0);

    // ---------------- empty FIFO, downstream ready (bypass behaviour) ----------------
    wbd_cmd_wrdy_i = 1'b1;
    wbp_cmd_wval_i = 1'b1;
    wbp_cmd_pkt_i  = mk_cmd(32'h5000_0000, 1'b1, 32'h1234_5678, 4'hC, 4'd7, 10'd4);
    #1;
    check("byp_same_cycle_wval", wbd_cmd_wval_o, BYP);
    tick();
    wbp_cmd_wval_i = 1'b0;
    wbp_cmd_pkt_i  = '0;
    #1;
    check("byp_level_after", cmd_level_o, BYP ? 0 : 1);
    check("byp_wval_after", wbd_cmd_wval_o, BYP ? 0 : 1);
    tick();
    check("byp_final_empty", cmd_level_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
